// File: rtl/mem_arbiter_if.sv
// Bundle between the cache requesters, the memory arbiter and shared main memory.
// master = arbiter side; slave = caches plus memory.
interface mem_arbiter_if #(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16
);
   logic [NUM_PORTS-1:0]        req_rd;
   logic [NUM_PORTS-1:0]        req_wr;
   logic [NUM_PORTS*ADDR_W-1:0] req_addr;
   logic [NUM_PORTS*DATA_W-1:0] req_wdata;
   logic [NUM_PORTS-1:0]        grant;
   logic [NUM_PORTS-1:0]        stall;
   logic [NUM_PORTS-1:0]        rsp_vld;
   logic [DATA_W-1:0]           rsp_data;
   logic                        mem_en;
   logic                        mem_wr;
   logic [ADDR_W-1:0]           mem_addr;
   logic [DATA_W-1:0]           mem_wdata;
   logic [DATA_W-1:0]           mem_rdata;
   logic                        mem_data_valid;
   logic                        err;

   modport master (
      input  req_rd, req_wr, req_addr, req_wdata, mem_rdata, mem_data_valid,
      output grant, stall, rsp_vld, rsp_data, mem_en, mem_wr, mem_addr, mem_wdata, err
   );
   modport slave (
      output req_rd, req_wr, req_addr, req_wdata, mem_rdata, mem_data_valid,
      input  grant, stall, rsp_vld, rsp_data, mem_en, mem_wr, mem_addr, mem_wdata, err
   );
endinterface

// File: rtl/mem_arbiter.sv
// N-port arbiter in front of a single pipelined main memory; the grant is held for a
// whole burst and until every read issued under it has returned.
module mem_arbiter #(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int RR_MODE   = 0,
   parameter int MAX_OUT   = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_arbiter_if.master bus
);
   localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int CNT_W = $clog2(MAX_OUT + 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_GRANT = 2'd1, S_DRAIN = 2'd2} state_e;

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     owner_q, owner_d, last_q, last_d, winner;
   logic [NUM_PORTS-1:0] grant_q, grant_d, req_any;
   logic [CNT_W-1:0]     out_q, out_d;
   logic                 err_q, err_d;
   logic                 own_rd, own_wr, full, issue, retire, found;
   int                   scan_idx;

   assign req_any = bus.req_rd | bus.req_wr;
   assign own_rd  = bus.req_rd[owner_q];
   assign own_wr  = bus.req_wr[owner_q];
   // A returning word frees a slot in the same cycle, so full only holds without one.
   assign full    = (out_q == CNT_W'(MAX_OUT)) & ~bus.mem_data_valid;
   assign retire  = bus.mem_data_valid & (out_q != '0);
   assign issue   = (state_q == S_GRANT) & own_rd & ~own_wr & ~full;
   assign out_d   = out_q + CNT_W'(issue) - CNT_W'(retire);
   assign err_d   = err_q | (bus.mem_data_valid & (out_q == '0));

   // Fixed: scan from port 0. Round-robin: scan from last+1 with wrap.
   always_comb begin
      winner   = '0;
      found    = 1'b0;
      scan_idx = 0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         scan_idx = (RR_MODE != 0) ? int'(last_q) + k : k - 1;
         if (scan_idx >= NUM_PORTS) scan_idx = scan_idx - NUM_PORTS;
         if (!found && req_any[scan_idx]) begin
            winner = IDX_W'(scan_idx);
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      grant_d    = grant_q;
      bus.mem_en = 1'b0;
      bus.mem_wr = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               state_d          = S_GRANT;
               owner_d          = winner;
               grant_d          = '0;
               grant_d[winner]  = 1'b1;
               if (RR_MODE != 0) last_d = winner;
            end
         end
         S_GRANT: begin
            bus.mem_wr = own_wr;
            bus.mem_en = own_wr | (own_rd & ~full);
            if (!own_rd && !own_wr) state_d = (out_d == '0) ? S_IDLE : S_DRAIN;
         end
         S_DRAIN: if (out_d == '0) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (state_d == S_IDLE) grant_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         owner_q <= '0;
         last_q  <= IDX_W'(NUM_PORTS - 1);
         grant_q <= '0;
         out_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         out_q   <= out_d;
         err_q   <= err_d;
      end
   end

   assign bus.grant     = grant_q;
   assign bus.stall     = ~grant_q | (grant_q & {NUM_PORTS{full}});
   assign bus.rsp_data  = bus.mem_rdata;
   assign bus.mem_addr  = bus.req_addr[int'(owner_q)*ADDR_W +: ADDR_W];
   assign bus.mem_wdata = bus.req_wdata[int'(owner_q)*DATA_W +: DATA_W];
   assign bus.err       = err_q;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_rsp
      assign bus.rsp_vld[i] = retire & (int'(owner_q) == i);
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Parametrised N-port arbiter between cache controllers (I-cache, D-cache, future ports) and the single shared pipelined `memory4c` main memory.
- Grants one requester at a time and locks the grant for a whole block fill or write-back burst.
- Tracks in-flight reads so every returning `data_valid` reaches the port that issued the read.
- Supports fixed-priority or round-robin arbitration; replaces the two-port, combinational, I-cache-first mux.

## Interface
Parameters:
- `NUM_PORTS`, 2, number of requesters; port 0 is the I-cache by convention.
- `ADDR_W`, 16, address width.
- `DATA_W`, 16, data width.
- `RR_MODE`, 0, 0 = fixed priority (lowest index wins); 1 = round-robin.
- `MAX_OUT`, 8, maximum in-flight reads; counter width `$clog2(MAX_OUT+1)`.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `req_rd` input NUM_PORTS: per-port read request (`read_req` of each cache).
- `req_wr` input NUM_PORTS: per-port write request (`wrt_mem` of each cache).
- `req_addr` input NUM_PORTS*ADDR_W: flattened addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- `req_wdata` input NUM_PORTS*DATA_W: flattened write data.
- `grant` output NUM_PORTS: one-hot registered owner indication.
- `stall` output NUM_PORTS: port may not issue this cycle.
- `rsp_vld` output NUM_PORTS: per-port data valid (the cache's `mem_data_vld`).
- `rsp_data` output DATA_W: `mem_rdata` passthrough, shared by all ports.
- `mem_en`, `mem_wr` output 1: memory enable and write.
- `mem_addr` output ADDR_W: memory address.
- `mem_wdata` output DATA_W: memory write data.
- `mem_rdata` input DATA_W: memory read data.
- `mem_data_valid` input 1: memory read data valid.
- `err` output 1: sticky flag, set on `mem_data_valid` with zero reads outstanding.

## Operation
- State: `owner` index, 2-bit FSM, `outstanding` counter, `last` pointer (round-robin only).
- **IDLE**
  - `grant` = 0; `mem_en` = 0.
  - If any `req_rd|req_wr` bit is set, pick a winner and go to GRANT with `owner` = winner and `grant` one-hot = winner.
  - Fixed priority (`RR_MODE`=0): lowest requesting index wins.
  - Round-robin (`RR_MODE`=1): first requesting index scanning from `last+1` with wrap; `last` <= winner.
- **GRANT**
  - `mem_en` = `req_rd[owner] | req_wr[owner]`.
  - `mem_wr` = `req_wr[owner]`; write wins if both are asserted.
  - `mem_addr` and `mem_wdata` come from the owner's slice.
  - Read issue occurs when `mem_en & ~mem_wr & ~stall[owner]`.
  - When `req_rd[owner]` and `req_wr[owner]` are both low: go to IDLE if the next `outstanding` is 0, otherwise go to DRAIN.
  - Other requests are ignored while locked; no preemption.
- **DRAIN**
  - `grant` stays on `owner`; `mem_en` = 0.
  - Go to IDLE in the cycle the next `outstanding` becomes 0.
- **Counter**
  - +1 on read issue; −1 on `mem_data_valid` while nonzero.
  - Both in the same cycle leaves it unchanged.
  - It never exceeds `MAX_OUT`.
- **stall**
  - `stall[i]` = `~grant[i]`.
  - Also asserted for the owner when `outstanding==MAX_OUT & ~mem_data_valid`.
  - A stalled read must not drive `mem_en`.
- **Responses**
  - `rsp_vld[owner]` = `mem_data_valid & (outstanding!=0)`; all other ports read 0.
  - Writes produce no response.
- **Error**
  - `mem_data_valid` with `outstanding==0` produces no `rsp_vld` and sets `err`.
  - `err` clears only on reset.

## Timing
- Reset (async, `rst_n`=0):
  - FSM = IDLE; `owner` = 0; `outstanding` = 0; `last` = NUM_PORTS−1; `err` = 0.
  - `grant`, `rsp_vld`, `mem_en`, `mem_wr` = 0; `mem_addr`/`mem_wdata` = port 0 slice.
  - `stall` = all ones.
- Reset mid-burst discards outstanding reads; later `mem_data_valid` pulses set `err` only if they arrive after reset release.
- Arbitration latency: a request seen at edge k gives `grant` high after edge k+1; first `mem_en` in cycle k+1.
- All memory-side outputs are combinational from `grant`/owner inputs (zero added latency).
- Response latency is the memory's (4 cycles for `memory4c`).
- Burst of B back-to-back reads takes B issue cycles plus the drain of the memory latency before re-arbitration.
- Ownership handoff has ≥1 idle cycle (the IDLE cycle).

## Test plan
- Fixed mode, port 0 issues 8 reads 0x0100–0x010E one per cycle, 4-cycle memory latency:
  - `grant`=01 for the burst plus 3 drain cycles;
  - eight `rsp_vld[0]` pulses with correct data; `rsp_vld[1]` never asserts.
- Fixed mode, both ports request in the same cycle: port 0 granted first; port 1 granted on the first IDLE after port 0's drain.
- `RR_MODE`=1, both ports request continuously with 1-word bursts: grants alternate 01,10,01,10; first grant is port 0 after reset.
- D-cache write-back of 8 words at 0x2000: `mem_wr`=1 for 8 cycles; no `rsp_vld`; IDLE the cycle after `req_wr` drops.
- `MAX_OUT`=2, owner holds `req_rd` with 4-cycle latency: `stall[owner]` asserts after 2 issues; never more than 2 in flight.
- Spurious `mem_data_valid` in IDLE sets `err`=1 with no `rsp_vld`; `rst_n` low mid-burst clears `grant` and `err` immediately.
